sa_requester: RTL
=================

Name: sa_requester

Overview:
Per-input-port requester that pairs with the round-robin arbiter in a VC router's switch-allocation stage.
- Keeps one downstream credit counter per VC.
- Drives one request line per VC into the arbiter and takes its one-hot grant back in the same cycle.
- Pops the granted VC buffer and tracks per-VC packet state from head flit to tail flit.
- Flags protocol violations: grant with no matching request, and credit overflow.

Parameters:
V, 4, number of virtual channels, which is also the arbiter width.
CREDIT_DEPTH, 4, downstream VC buffer depth in flits; reset value of every credit counter; must be at least 1.
CW, log2(CREDIT_DEPTH+1), credit counter width; derived, never overridden.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
flit_valid  in  V  VC buffer v is non-empty.
flit_is_head  in  V  head-of-buffer flit of VC v is a head flit.
flit_is_tail  in  V  head-of-buffer flit of VC v is a tail flit; a single-flit packet asserts both head and tail.
credit_in  in  V  one-cycle pulse returns one credit for VC v.
grant  in  V  one-hot grant from the arbiter, combinational from request.
any_grant  in  1  arbiter anyGrant.
request  out  V  request vector to the arbiter.
flit_rd  out  V  pops VC buffer v; at most one bit set.
vc_active  out  V  VC v is mid-packet.
credit_cnt  out  V*CW  packed credit counters; VC v occupies bits [v*CW +: CW].
err_grant  out  1  sticky: grant seen outside request, or grant not one-hot.
err_credit  out  1  sticky: credit returned while counter already at CREDIT_DEPTH.

Behaviour:
- Reset (asynchronous): every credit counter = CREDIT_DEPTH; every VC state = IDLE; vc_active = 0; err_grant = err_credit = 0.
  - request and flit_rd are combinational, so they equal 0 whenever flit_valid = 0.
- Request: request[v] = flit_valid[v] & (cnt[v] != 0). Purely combinational from registered counters and inputs, so the arbiter grant resolves in the same cycle.
- Pop: flit_rd = grant & request & {V{any_grant}}. This gives zero-cycle latency from grant to pop.
- Credit counters, updated every posedge, dec[v] = flit_rd[v], inc[v] = credit_in[v]:
  - inc and dec together: counter unchanged.
  - dec only: cnt - 1. Underflow cannot occur because request requires cnt != 0.
  - inc only with cnt == CREDIT_DEPTH: counter holds and err_credit is set.
  - inc only otherwise: cnt + 1.
- Per-VC packet FSM, two states, IDLE and ACTIVE:
  - IDLE -> ACTIVE when flit_rd[v] & flit_is_head[v] & ~flit_is_tail[v].
  - ACTIVE -> IDLE when flit_rd[v] & flit_is_tail[v].
  - IDLE with a head+tail flit popped: stays IDLE.
  - A head flit popped while ACTIVE is a protocol error: err_grant is set and the state stays ACTIVE.
  - vc_active[v] = (state == ACTIVE), registered.
- err_grant is set on any of:
  - grant & ~request != 0;
  - grant has more than one bit set;
  - any_grant = 1 with grant = 0.
  - An erroneous grant bit never pops a buffer: the masking by request handles this.
- Errors are sticky until reset.
- Reset asserted mid-packet: all FSMs return to IDLE and counters return to full on the next evaluation. No pop happens while reset is held, because the outputs are forced low during reset.
- Counters never wrap: the range is 0..CREDIT_DEPTH inclusive.

Decomposition:
- Shared package/define include:
  - FSM state encoding: IDLE = 1'b0, ACTIVE = 1'b1.
  - the log2 helper already used by the arbiter, for CW.
- One natural sub-module, sa_credit_counter: a single-VC up/down counter with saturation and overflow flag. Instantiate V times in a generate loop.
- The FSM and request/pop logic stay in the top level.

Test Plan:
1. Reset, then flit_valid = 4'b0001 with head+tail, arbiter grants 4'b0001 -> request = 4'b0001, flit_rd = 4'b0001 in the same cycle; credit_cnt[0] goes 4 -> 3 next cycle; vc_active stays 0.
2. VC1 sends head, body, body, body with no credit return -> cnt[1] goes 4 -> 0; vc_active[1] = 1 after the head; when cnt[1] = 0, request[1] = 0 even though flit_valid[1] = 1. One credit_in[1] pulse -> request[1] = 1 the next cycle; tail popped -> vc_active[1] = 0.
3. credit_in[2] and flit_rd[2] in the same cycle with cnt[2] = 2 -> cnt[2] stays 2; no error.
4. credit_in[3] with cnt[3] = 4 -> cnt[3] stays 4; err_credit = 1 and stays 1 until reset.
5. Force grant = 4'b0100 while request = 4'b0001 -> flit_rd = 0; err_grant = 1. Also force grant = 4'b0011 -> err_grant = 1.
6. All four VCs valid with full credits, driven by the real arbiter with CHOISE = 1 for 8 cycles -> pops rotate VC0, VC1, VC2, VC3, VC0, ...; each counter drops by 2; no errors. Then assert reset mid-packet -> all counters return to 4 and vc_active = 0 immediately.

Source files
------------

// File: rtl/sa_requester_pkg.sv
// Shared types and helpers for the switch-allocation requester.
// The state encoding and log2 helper match the ones the arbiter uses.
package sa_requester_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } vc_state_e;

    // Ceiling log2: the smallest r with 2**r >= x.
    function automatic int unsigned log2c(input int unsigned x);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(x)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sa_credit_counter.sv
// Single-VC downstream credit counter covering 0..CREDIT_DEPTH.
// It saturates at both ends. o_overflow pulses when a credit returns while the counter is already full.
module sa_credit_counter
    import sa_requester_pkg::*;
#(
    parameter int unsigned CREDIT_DEPTH = 4,
    parameter int unsigned CW           = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_cnt,
    output logic          o_overflow
);

    localparam logic [CW-1:0] FULL = CW'(CREDIT_DEPTH);

    logic [CW-1:0] r_cnt;
    logic          w_full;
    logic          w_empty;

    assign w_full     = (r_cnt == FULL);
    assign w_empty    = (r_cnt == '0);
    assign o_overflow = i_inc & ~i_dec & w_full;
    assign o_cnt      = r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= FULL;
        end else if (i_inc & ~i_dec & ~w_full) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (i_dec & ~i_inc & ~w_empty) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/sa_requester.sv
// Per-input-port switch-allocation requester.
// It holds per-VC credits, issues requests and pops, tracks packet state and raises sticky protocol errors.
module sa_requester
    import sa_requester_pkg::*;
#(
    parameter  int unsigned V            = 4,
    parameter  int unsigned CREDIT_DEPTH = 4,
    localparam int unsigned CW           = log2c(CREDIT_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [V-1:0]    flit_valid,
    input  logic [V-1:0]    flit_is_head,
    input  logic [V-1:0]    flit_is_tail,
    input  logic [V-1:0]    credit_in,
    input  logic [V-1:0]    grant,
    input  logic            any_grant,
    output logic [V-1:0]    request,
    output logic [V-1:0]    flit_rd,
    output logic [V-1:0]    vc_active,
    output logic [V*CW-1:0] credit_cnt,
    output logic            err_grant,
    output logic            err_credit
);

    logic [V-1:0] w_has_credit;
    logic [V-1:0] w_overflow;
    logic [V-1:0] w_request;
    logic [V-1:0] w_flit_rd;
    logic [V-1:0] w_head_err;
    logic         w_grant_err;

    vc_state_e    r_state     [V];
    vc_state_e    w_state_nxt [V];

    logic         r_err_grant;
    logic         r_err_credit;

    for (genvar v = 0; v < V; v++) begin : g_vc
        logic [CW-1:0] w_cnt;

        sa_credit_counter #(
            .CREDIT_DEPTH (CREDIT_DEPTH),
            .CW           (CW)
        ) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .i_inc      (credit_in[v]),
            .i_dec      (w_flit_rd[v]),
            .o_cnt      (w_cnt),
            .o_overflow (w_overflow[v])
        );

        assign w_has_credit[v]        = (w_cnt != '0);
        assign credit_cnt[v*CW +: CW] = w_cnt;
        assign vc_active[v]           = (r_state[v] == ACTIVE);
    end

    // Forcing the outputs low during reset prevents a pop while reset is held.
    assign w_request = flit_valid & w_has_credit & {V{~reset}};
    assign w_flit_rd = grant & w_request & {V{any_grant}};
    assign request   = w_request;
    assign flit_rd   = w_flit_rd;

    assign w_grant_err = ((grant & ~w_request) != '0)
                       | ((grant & (grant - V'(1))) != '0)
                       | (any_grant & (grant == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < V; i++) r_state[i] <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A head flit popped mid-packet takes priority over its tail bit: the VC stays ACTIVE.
    always_comb begin
        w_state_nxt = r_state;
        w_head_err  = '0;
        for (int unsigned i = 0; i < V; i++) begin
            unique case (r_state[i])
                IDLE: begin
                    if (w_flit_rd[i] & flit_is_head[i] & ~flit_is_tail[i])
                        w_state_nxt[i] = ACTIVE;
                end
                ACTIVE: begin
                    if (w_flit_rd[i] & flit_is_head[i])
                        w_head_err[i] = 1'b1;
                    else if (w_flit_rd[i] & flit_is_tail[i])
                        w_state_nxt[i] = IDLE;
                end
                default: w_state_nxt[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_grant  <= 1'b0;
            r_err_credit <= 1'b0;
        end else begin
            if (w_grant_err | (w_head_err != '0)) r_err_grant  <= 1'b1;
            if (w_overflow != '0)                 r_err_credit <= 1'b1;
        end
    end

    assign err_grant  = r_err_grant;
    assign err_credit = r_err_credit;

endmodule
